// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: opcode/funct encodings, instruction field
// positions and the fetch-unit state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicing of a MIPS32 instruction word into its fields.
module instr_field_split
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm
);

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm    = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem request and a
// one-entry instruction buffer toward decode, with jump/branch redirect.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [15:0]       imm,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              misalign
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              drop;
    logic              vld_p1;
    logic [31:0]       instr_p1;
    logic [ADDR_W-1:0] pc_out_p1;
    logic              misalign_p1;

    logic              redirect;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] target;
    logic              capture;

    assign redirect   = jump | branch_taken;
    assign raw_target = jump ? jump_target : branch_target;
    assign target     = {raw_target[ADDR_W-1:2], 2'b00};
    // A redirect in the same cycle as rvalid makes the returning word stale.
    assign capture    = (state == WAIT) && imem_rvalid && !drop && !redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (imem_gnt) state_nxt = WAIT;
            WAIT:  if (imem_rvalid) state_nxt = capture ? HOLD : FETCH;
            HOLD: begin
                if (redirect)      state_nxt = FETCH;
                else if (if_ready) state_nxt = imem_gnt ? WAIT : FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // HOLD re-issues only in the cycle the buffer drains, and never toward a stale PC.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            FETCH:   imem_req = !reset;
            HOLD:    imem_req = !reset && if_ready && !redirect;
            default: imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            drop        <= 1'b0;
            vld_p1      <= 1'b0;
            misalign_p1 <= 1'b0;
            instr_p1    <= NOP_WORD;
        end else begin
            misalign_p1 <= redirect && (raw_target[1:0] != 2'b00);
            if (redirect) begin
                pc <= target;
            end else if (capture) begin
                pc <= pc + ADDR_W'(4);
            end
            if (redirect && ((state == FETCH && imem_gnt) || (state == WAIT && !imem_rvalid))) begin
                drop <= 1'b1;
            end else if (state == WAIT && imem_rvalid) begin
                drop <= 1'b0;
            end
            if (redirect) begin
                vld_p1 <= 1'b0;
            end else if (capture) begin
                vld_p1 <= 1'b1;
            end else if (if_ready) begin
                vld_p1 <= 1'b0;
            end
            if (capture) begin
                instr_p1 <= imem_rdata;
            end
        end
    end

    // Buffer address carries no reset; it is only meaningful while if_valid is set.
    always_ff @(posedge clk) begin
        if (capture) begin
            pc_out_p1 <= pc;
        end
    end

    assign imem_addr = pc;
    assign if_valid  = vld_p1;
    assign instr     = instr_p1;
    assign pc_out    = pc_out_p1;
    assign pc_plus4  = pc_out_p1 + ADDR_W'(4);
    assign misalign  = misalign_p1;

    instr_field_split u_split (
        .instr  (instr_p1),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .funct  (funct),
        .imm    (imm)
    );

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch front end for the single-core Harvard MIPS32. Holds the PC, issues reads to the instruction memory port, and buffers one fetched word. It presents opcode/funct and the other instruction fields to the control unit and decode stage. It accepts jump/branch redirects back from the control/execute side, and is the producer end of the control unit's opcode/funct interface.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- ADDR_W, 32, instruction address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  word-aligned read address; held stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; arrives 1 or more cycles after grant.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  buffered instruction valid toward decode.
- if_ready  in  1  decode consumes the buffered instruction this cycle when if_valid=1.
- instr  out  32  buffered instruction word.
- pc_out  out  ADDR_W  address of the buffered instruction.
- pc_plus4  out  ADDR_W  pc_out+4.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- shamt  out  5  instr[10:6].
- imm  out  16  instr[15:0].
- jump  in  1  redirect request from the control unit (j).
- jump_target  in  ADDR_W  jump destination.
- branch_taken  in  1  taken beq/bne resolved downstream.
- branch_target  in  ADDR_W  branch destination.
- misalign  out  1  one-cycle pulse when a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (synchronous, active-high; wins over every other input): pc=RESET_PC, state=FETCH, drop=0. if_valid, imem_req and misalign are 0, and instr is 32'h0 (NOP), so opcode/funct/fields all read 0.
- States:
  - FETCH: imem_req=1, imem_addr=pc. If imem_gnt, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, go to FETCH if the output buffer is free in the next cycle, else HOLD.
  - HOLD: buffer full and stalled; stay until if_ready.
- Capture: on imem_rvalid with drop=0, set instr=imem_rdata, pc_out=pc, if_valid=1, pc=pc+4. This gives a minimum two-cycle latency from grant to if_valid.
- Throughput: a new request may be issued in the same cycle the buffer is consumed (if_valid&if_ready). Only one request is ever outstanding.
- Stall: while if_valid=1 and if_ready=0, instr, pc_out and all fields hold constant and no new request is issued.
- Redirect: jump has priority over branch_taken. On either:
  - pc = target with bits [1:0] forced to 0; misalign pulses if the original bits were nonzero.
  - if_valid clears next cycle.
  - In FETCH without grant: imem_addr switches to the target next cycle.
  - In FETCH with grant in the same cycle, or in WAIT: set drop=1. The matching rvalid is discarded (no capture, no pc increment), drop clears, and the unit returns to FETCH at the target.
  - In HOLD: the buffer is flushed and the unit goes to FETCH.
  - A redirect in the same cycle as rvalid: the data is discarded and the target wins.
- PC arithmetic wraps modulo 2^ADDR_W; 32'hFFFF_FFFC+4 = 0.
- Reset during WAIT: the late rvalid arriving after reset is ignored, because the unit is in FETCH and not waiting.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTIU)
  - funct constants (F_ADD, F_SUB, F_SLL)
  - instruction field bit positions
  - NOP word
  - fetch state enum (FETCH, WAIT, HOLD)
- One sub-module, instr_field_split: purely combinational slicing of instr into opcode/rs/rt/rd/shamt/funct/imm, reused by decode later.

Test Plan:
- Reset, then imem_gnt=1 always and rvalid one cycle after grant, with words 8C010004 (lw), AC010008 (sw), 00221820 (add) -> if_valid sequence with pc_out 0, 4, 8; opcode 23, 2B, 00; funct 20 on the third.
- if_ready=0 for 5 cycles after the first capture -> instr/pc_out stable, imem_req=0 throughout; if_ready=1 -> next request at addr 4 in the same cycle.
- jump=1, jump_target=0x40 while in WAIT -> in-flight rdata discarded, next imem_addr=0x40, next valid pc_out=0x40.
- jump=1 (target 0x80) and branch_taken=1 (target 0x20) in the same cycle -> fetch from 0x80.
- branch_target=0x0000_0036 -> imem_addr=0x34, misalign pulses for exactly one cycle.
- reset asserted in WAIT with rvalid the next cycle -> if_valid stays 0, imem_addr=RESET_PC, instr=0.
